cdc_tx_arbiter: RTL and testbench

Source-domain controller that shares one enable-qualified CDC synchronizer channel among N requesters. It round-robin arbitrates the requesters and captures the winner's word. It drives the channel's data and enable, then completes a four-phase enable/acknowledge handshake with the destination domain before the next requester is served. The block sits entirely in the source clock domain, directly in front of the synchronizer's data and enable inputs. The returning acknowledge is synchronized internally.

---
 rtl/cdc_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_cdc_tx_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_tx_arbiter.sv
// cdc_tx_arbiter: round-robin arbiter feeding one enable-qualified CDC
// synchronizer channel. It completes a four-phase enable/ack handshake per word.
// Optional ack timeout/abort is compiled in with `define CDC_ARB_TIMEOUT_EN.
module cdc_tx_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_W-1:0]     req_data,
  output logic [N_REQ-1:0]            done,
  output logic [DATA_W-1:0]           sync_data,
  output logic                        sync_enable,
  input  logic                        ack_async,
  output logic                        busy,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        err
);

  localparam int unsigned GW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("cdc_tx_arbiter: unsupported parameter set");
  end

`ifdef CDC_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_DROP, S_DONE, S_ABORT} state_t;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DROP, S_DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              enable_q, enable_d;
  logic              busy_q, busy_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              ack_meta_q, ack_s_q;
  logic              win_found;
  logic [GW-1:0]     win_idx;
  logic [GW-1:0]     next_ptr;

  // Rotating priority search: first set req at or above ptr, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!win_found && req[(32'(ptr_q) + 32'(i)) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = GW'((32'(ptr_q) + 32'(i)) % N_REQ);
      end
    end
  end

  assign next_ptr = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);

  // Next-state logic; outputs are decoded from the next state so they register.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        // A high synchronized ack here is stale; hold off until it clears.
        if (win_found && !ack_s_q) begin
          state_d = S_SEND;
          grant_d = win_idx;
          data_d  = req_data[32'(win_idx) * DATA_W +: DATA_W];
        end
      end
      S_SEND: begin
        if (ack_s_q) begin
          state_d = S_DROP;
`ifdef CDC_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ABORT;
          ptr_d   = next_ptr;
`endif
        end
      end
      S_DROP: begin
        if (!ack_s_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = next_ptr;
      end
`ifdef CDC_ARB_TIMEOUT_EN
      S_ABORT: begin
        if (!ack_s_q) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    enable_d = (state_d == S_SEND);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE) ? (N_REQ'(1) << grant_q) : '0;
`ifdef CDC_ARB_TIMEOUT_EN
    cnt_d    = (state_q == S_SEND) ? cnt_q + CNT_W'(1) : '0;
    err_d    = (state_d == S_ABORT) && (state_q != S_ABORT);
`endif
  end

  // State, ack synchronizer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      data_q     <= '0;
      enable_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= '0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      enable_q   <= enable_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_meta_q <= ack_async;
      ack_s_q    <= ack_meta_q;
    end
  end

`ifdef CDC_ARB_TIMEOUT_EN
  // SEND-cycle counter and abort error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign sync_data   = data_q;
  assign sync_enable = enable_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Self-checking bench for cdc_tx_arbiter: directed scenarios plus randomized
// request traffic, checked against a transaction-level round-robin model.
module tb_cdc_tx_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   done;
  logic [W-1:0]   sync_data;
  logic           sync_enable;
  logic           ack_async;
  logic           busy;
  logic [1:0]     grant_id;
  logic           err;

  int n_cmp = 0;
  int n_err = 0;
  int ptr   = 0;  // model rotation pointer

  cdc_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .done(done),
    .sync_data(sync_data), .sync_enable(sync_enable), .ack_async(ack_async),
    .busy(busy), .grant_id(grant_id), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: first requester at or above ptr, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < int'(N); k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One full handshake for requester id; block must be IDLE with req set.
  task automatic xfer(input int id, input int dly);
    logic [W-1:0] exp_d;
    logic [N-1:0] exp_done;
    exp_d    = req_data[id*W +: W];
    exp_done = '0;
    exp_done[id] = 1'b1;
    tick();
    chk("grant_en", sync_enable, 1);
    chk("grant_data", sync_data, exp_d);
    chk("grant_id", grant_id, id);
    chk("grant_busy", busy, 1);
    chk("grant_err", err, 0);
    req_data[id*W +: W] = $urandom();  // must not disturb captured word
    repeat (dly) tick();
    chk("send_hold_en", sync_enable, 1);
    chk("send_hold_data", sync_data, exp_d);
    ack_async = 1'b1;
    tick();
    tick();
    chk("en_before_drop", sync_enable, 1);
    tick();
    chk("en_drop", sync_enable, 0);
    chk("drop_data", sync_data, exp_d);
    chk("drop_done", done, 0);
    ack_async = 1'b0;
    tick();
    tick();
    chk("done_early", done, 0);
    tick();
    chk("done_pulse", done, exp_done);
    chk("done_busy", busy, 1);
    chk("done_id", grant_id, id);
    req[id] = 1'b0;
    ptr = (id + 1) % N;
    tick();
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_data", sync_data, exp_d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_en", sync_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", sync_data, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_err", err, 0);
    tick();
    rst = 1'b0;
    ptr = 0;
  endtask

  initial begin
    int w;
    logic [N-1:0] nb;
    rst = 1'b1;
    req = '0;
    req_data = '0;
    ack_async = 1'b0;
    tick();
    do_reset();

    // Single transfer.
    req_data[0*W +: W] = 32'hDEADBEEF;
    req = 4'b0001;
    xfer(0, 1);

    // Round robin from ptr=0 with all four requesting.
    do_reset();
    for (int k = 0; k < int'(N); k++) req_data[k*W +: W] = $urandom();
    req = 4'b1111;
    for (int k = 0; k < int'(N); k++) begin
      w = pick(req, ptr);
      xfer(w, $urandom_range(0, 3));
    end
    req = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      w = pick(req, ptr);
      xfer(w, $urandom_range(0, 3));
    end

    // Stale ack blocks arbitration until it clears.
    ack_async = 1'b1;
    repeat (3) tick();
    req_data[1*W +: W] = $urandom();
    req = 4'b0010;
    repeat (4) begin
      tick();
      chk("stale_no_en", sync_enable, 0);
      chk("stale_busy", busy, 0);
    end
    ack_async = 1'b0;
    tick();
    tick();
    chk("stale_clear_no_en", sync_enable, 0);
    xfer(1, 0);

    // Randomized traffic; pending requests stay held until served.
    for (int it = 0; it < 24; it++) begin
      nb = 4'($urandom_range(1, 15));
      for (int k = 0; k < int'(N); k++)
        if (!req[k] && nb[k]) req_data[k*W +: W] = $urandom();
      req = req | nb;
      w = pick(req, ptr);
      xfer(w, $urandom_range(0, 3));
    end
    req = '0;
    tick();

    // Reset in SEND with grant_id=2: abandoned, no done.
    req_data[2*W +: W] = $urandom();
    req = 4'b0100;
    tick();
    chk("mid_gid", grant_id, 2);
    chk("mid_en", sync_enable, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_en", sync_enable, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    req = '0;
    tick();
    rst = 1'b0;
    ptr = 0;
    repeat (4) begin
      tick();
      chk("mid_no_done", done, 0);
    end
    // ptr back at 0: requester 1 beats requester 3.
    req_data[1*W +: W] = $urandom();
    req_data[3*W +: W] = $urandom();
    req = 4'b1010;
    w = pick(req, ptr);
    xfer(w, 0);
    w = pick(req, ptr);
    xfer(w, 0);

`ifdef CDC_ARB_TIMEOUT_EN
    // Ack never rises: abort after 16 SEND cycles, then next requester served.
    req_data[2*W +: W] = $urandom();
    req = 4'b0100;
    tick();
    chk("to_grant", grant_id, 2);
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("to_wait_en", sync_enable, 1);
      chk("to_wait_err", err, 0);
    end
    tick();
    chk("to_en_drop", sync_enable, 0);
    chk("to_err", err, 1);
    chk("to_no_done", done, 0);
    req = '0;
    ptr = 3;
    tick();
    chk("to_err_once", err, 0);
    chk("to_no_done2", done, 0);
    chk("to_idle", busy, 0);
    req_data[0*W +: W] = $urandom();
    req_data[3*W +: W] = $urandom();
    req = 4'b1001;
    w = pick(req, ptr);
    xfer(w, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
